// File: rtl/amo_pkg.sv
// Shared opcode, state and operation definitions for the atomic memory operation engine.
package amo_pkg;

  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SWAP,
    OP_LR,
    OP_SC,
    OP_XOR,
    OP_OR,
    OP_AND,
    OP_MIN,
    OP_MAX,
    OP_MINU,
    OP_MAXU
  } amo_op_e;

  // Unrecognised funct5 codes behave as SWAP.
  function automatic amo_op_e decode_op(input logic [4:0] f);
    case (f)
      F5_ADD:  return OP_ADD;
      F5_LR:   return OP_LR;
      F5_SC:   return OP_SC;
      F5_XOR:  return OP_XOR;
      F5_OR:   return OP_OR;
      F5_AND:  return OP_AND;
      F5_MIN:  return OP_MIN;
      F5_MAX:  return OP_MAX;
      F5_MINU: return OP_MINU;
      F5_MAXU: return OP_MAXU;
      default: return OP_SWAP;
    endcase
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write function: new memory value from old value and rs2.
module amo_alu
  import amo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  input  logic [4:0]      funct5,
  output logic [XLEN-1:0] new_val
);

  logic signed [XLEN-1:0] old_s;
  logic signed [XLEN-1:0] opd_s;

  assign old_s = old_val;
  assign opd_s = operand;

  // Select the new value; MIN/MAX only replace old on a strict win so ties keep old.
  always_comb begin
    new_val = operand;
    case (decode_op(funct5))
      OP_ADD:  new_val = old_val + operand;
      OP_XOR:  new_val = old_val ^ operand;
      OP_OR:   new_val = old_val | operand;
      OP_AND:  new_val = old_val & operand;
      OP_MIN:  new_val = (opd_s < old_s) ? operand : old_val;
      OP_MAX:  new_val = (opd_s > old_s) ? operand : old_val;
      OP_MINU: new_val = (operand < old_val) ? operand : old_val;
      OP_MAXU: new_val = (operand > old_val) ? operand : old_val;
      default: new_val = operand;
    endcase
  end

endmodule

// File: rtl/amo_engine.sv
// AMO / LR / SC sequencer: read-modify-write over a single-port memory handshake
// with a single-entry load reservation.
module amo_engine
  import amo_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter int RSV_GRAN_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_funct5,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_operand,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr
);

  localparam int ALIGN_W = $clog2(XLEN / 8);
  localparam int GRAN_W  = ADDR_W - RSV_GRAN_LOG2;

  state_e state, state_nxt;

  logic [4:0]        funct5_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   operand_q;
  logic [XLEN-1:0]   rdata_q;
  logic [XLEN-1:0]   wdata_q;
  logic              misalign_q;
  logic [XLEN-1:0]   alu_new;

  logic              rsv_valid;
  logic [GRAN_W-1:0] rsv_gran;

  logic accept, req_misaligned, req_is_lr, req_is_sc;
  logic snoop_hit_rsv, snoop_hit_lr, sc_success, lr_done;
  logic unused_snoop_bits;

  assign accept         = req_valid & req_ready;
  assign req_misaligned = (req_addr[ALIGN_W-1:0] != '0);
  assign req_is_lr      = (decode_op(req_funct5) == OP_LR);
  assign req_is_sc      = (decode_op(req_funct5) == OP_SC);

  // A snoop in the accept cycle already counts against the SC.
  assign snoop_hit_rsv = snoop_valid & rsv_valid &
                         (snoop_addr[ADDR_W-1:RSV_GRAN_LOG2] == rsv_gran);
  assign snoop_hit_lr  = snoop_valid &
                         (snoop_addr[ADDR_W-1:RSV_GRAN_LOG2] == addr_q[ADDR_W-1:RSV_GRAN_LOG2]);
  assign sc_success    = rsv_valid & ~snoop_hit_rsv &
                         (req_addr[ADDR_W-1:RSV_GRAN_LOG2] == rsv_gran);
  assign lr_done       = (state == S_READ) & mem_resp & (decode_op(funct5_q) == OP_LR);

  assign unused_snoop_bits = ^snoop_addr[RSV_GRAN_LOG2-1:0];

  amo_alu #(.XLEN(XLEN)) u_alu (
    .old_val (rdata_q),
    .operand (operand_q),
    .funct5  (funct5_q),
    .new_val (alu_new)
  );

  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign resp_rdata      = resp_valid ? rdata_q : '0;
  assign resp_misaligned = resp_valid & misalign_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; memory strobes are pure state decodes so reset drops them at once.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_misaligned) state_nxt = S_DONE;
          else if (req_is_sc) state_nxt = sc_success ? S_WRITE : S_DONE;
          else                state_nxt = S_READ;
        end
      end
      S_READ: begin
        mem_read = 1'b1;
        if (mem_resp) state_nxt = (decode_op(funct5_q) == OP_LR) ? S_DONE : S_CALC;
      end
      S_CALC:  state_nxt = S_WRITE;
      S_WRITE: begin
        mem_write = 1'b1;
        if (mem_resp) state_nxt = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latches, captured old value and write data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct5_q   <= '0;
      addr_q     <= '0;
      operand_q  <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        funct5_q   <= req_funct5;
        addr_q     <= req_addr;
        operand_q  <= req_operand;
        misalign_q <= req_misaligned;
        if (req_misaligned) begin
          rdata_q <= '0;
        end else if (req_is_sc) begin
          rdata_q <= sc_success ? '0 : {{(XLEN-1){1'b0}}, 1'b1};
          wdata_q <= req_operand;
        end
      end
      if ((state == S_READ) && mem_resp) rdata_q <= mem_rdata;
      if (state == S_CALC) wdata_q <= alu_new;
    end
  end

  // Reservation: SC always consumes it, LR sets it, a matching snoop kills it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsv_valid <= 1'b0;
      rsv_gran  <= '0;
    end else if (accept && req_is_sc && !req_misaligned) begin
      rsv_valid <= 1'b0;
    end else if (lr_done) begin
      rsv_valid <= ~snoop_hit_lr;
      rsv_gran  <= addr_q[ADDR_W-1:RSV_GRAN_LOG2];
    end else if (snoop_hit_rsv) begin
      rsv_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amo_engine.sv
// Self-checking bench for amo_engine: directed vector table, hand-written
// reservation/reset sequences, and randomized ops against a behavioural model.
module tb_amo_engine;

  localparam int XLEN = 32;
  localparam int ADDR_W = 32;
  localparam int GRAN = 3;  // 8-byte reservation granule so 0x200 and 0x204 share one

  localparam logic [4:0] T_ADD = 5'b00000, T_SWAP = 5'b00001, T_LR = 5'b00010,
                         T_SC = 5'b00011, T_XOR = 5'b00100, T_OR = 5'b01000,
                         T_AND = 5'b01100, T_MIN = 5'b10000, T_MAX = 5'b10100,
                         T_MINU = 5'b11000, T_MAXU = 5'b11100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [4:0] req_funct5 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_operand = '0;
  logic resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic mem_read, mem_write;
  logic [31:0] mem_rdata = '0;
  logic mem_resp = 1'b0;
  logic snoop_valid = 1'b0;
  logic [31:0] snoop_addr = '0;

  always #5 clk = ~clk;

  amo_engine #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RSV_GRAN_LOG2(GRAN)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct5(req_funct5), .req_addr(req_addr), .req_operand(req_operand),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int mem_lat = 0;
  bit hold_wr = 1'b0;
  int wait_cnt = 0;
  int n_rd = 0, n_wr = 0, n_access_cyc = 0, n_rw_overlap = 0;
  logic [31:0] last_wr_addr = '0;

  bit m_rsv_v = 1'b0;
  logic [31:0] m_rsv_g = '0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h1234;
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: responds after mem_lat waiting cycles; writes can be withheld.
  always @(negedge clk) begin
    if (mem_read && mem_write) n_rw_overlap++;
    mem_resp = 1'b0;
    mem_rdata = $urandom;
    if (reset || !(mem_read || mem_write)) begin
      wait_cnt = 0;
    end else begin
      n_access_cyc++;
      if (!(mem_write && hold_wr) && wait_cnt >= mem_lat) begin
        mem_resp = 1'b1;
        wait_cnt = 0;
        if (mem_read) begin
          mem_rdata = mem_get(mem_addr);
          n_rd++;
        end else begin
          mem[mem_addr] = mem_wdata;
          last_wr_addr = mem_addr;
          n_wr++;
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Issue one request from an idle negedge; returns at the next idle negedge.
  task automatic do_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] opd,
                       input int snoop_cyc, input logic [31:0] sa,
                       output logic [31:0] rd, output logic mis, output int lat);
    bit timeout;
    req_valid = 1'b1; req_funct5 = f; req_addr = a; req_operand = opd;
    snoop_valid = (snoop_cyc == 0); snoop_addr = sa;
    @(posedge clk); #1;
    req_valid = 1'b0; req_funct5 = ~f; req_addr = ~a; req_operand = ~opd;
    snoop_valid = (snoop_cyc == 1);
    lat = 0; timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 2) snoop_valid = 1'b0;
      if (resp_valid) begin timeout = 1'b0; break; end
    end
    snoop_valid = 1'b0;
    chk("resp_timeout", {31'b0, timeout}, 32'd0);
    rd = resp_rdata; mis = resp_misaligned;
    @(negedge clk);
  endtask

  task automatic do_snoop(input logic [31:0] sa);
    snoop_valid = 1'b1; snoop_addr = sa;
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a); sb = $signed(b);
    case (f)
      T_ADD:  return a + b;
      T_XOR:  return a ^ b;
      T_OR:   return a | b;
      T_AND:  return a & b;
      T_MIN:  return (sb < sa) ? b : a;
      T_MAX:  return (sb > sa) ? b : a;
      T_MINU: return (b < a) ? b : a;
      T_MAXU: return (b > a) ? b : a;
      default: return b;
    endcase
  endfunction

  // Behavioural model of one operation: expected response, traffic and latency.
  task automatic model_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] opd,
                          input int snoop_cyc, input logic [31:0] sa,
                          output logic [31:0] e_rd, output logic e_mis,
                          output int e_nrd, output int e_nwr, output int e_lat);
    logic [31:0] old;
    if (snoop_cyc == 0 && m_rsv_v && (sa >> GRAN) == m_rsv_g) m_rsv_v = 1'b0;
    e_mis = (a % 4) != 0;
    e_nrd = 0; e_nwr = 0; e_rd = 0;
    if (e_mis) begin
      e_rd = 0;
    end else if (f == T_LR) begin
      e_rd = ref_get(a); e_nrd = 1;
      m_rsv_v = 1'b1; m_rsv_g = a >> GRAN;
    end else if (f == T_SC) begin
      if (m_rsv_v && m_rsv_g == (a >> GRAN)) begin
        ref_mem[a] = opd; e_rd = 0; e_nwr = 1;
      end else begin
        e_rd = 1;
      end
      m_rsv_v = 1'b0;
    end else begin
      old = ref_get(a);
      ref_mem[a] = ref_alu(f, old, opd);
      e_rd = old; e_nrd = 1; e_nwr = 1;
    end
    if (snoop_cyc == 1 && m_rsv_v && (sa >> GRAN) == m_rsv_g) m_rsv_v = 1'b0;
    e_lat = 1 + (e_nrd + e_nwr) * (1 + mem_lat) + ((e_nrd == 1 && e_nwr == 1) ? 1 : 0);
  endtask

  typedef struct {
    logic [4:0]  f;
    logic [31:0] old;
    logic [31:0] opd;
    logic [31:0] exp_new;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] rd, pre;
    logic mis;
    int lat, s_rd, s_wr, s_acc, bad;
    bit saw;

    vecs[0]  = '{T_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    vecs[1]  = '{T_ADD,  32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[2]  = '{T_MIN,  32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF};
    vecs[3]  = '{T_MINU, 32'hFFFFFFFF, 32'h00000005, 32'h00000005};
    vecs[4]  = '{T_MAX,  32'hFFFFFFFF, 32'h00000005, 32'h00000005};
    vecs[5]  = '{T_MAXU, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF};
    vecs[6]  = '{T_MAX,  32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
    vecs[7]  = '{T_MIN,  32'h80000000, 32'h80000000, 32'h80000000};
    vecs[8]  = '{T_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    vecs[9]  = '{T_OR,   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF};
    vecs[10] = '{T_AND,  32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030};
    vecs[11] = '{T_SWAP, 32'h12345678, 32'hCAFEBABE, 32'hCAFEBABE};
    vecs[12] = '{5'b00101, 32'h11111111, 32'h22222222, 32'h22222222};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_mis", {31'b0, resp_misaligned}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table at 0x100, single-cycle memory
    foreach (vecs[i]) begin
      mem[32'h100] = vecs[i].old;
      do_op(vecs[i].f, 32'h100, vecs[i].opd, -1, 32'h0, rd, mis, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].old);
      chk($sformatf("vec%0d_mem", i), mem_get(32'h100), vecs[i].exp_new);
      chk($sformatf("vec%0d_lat", i), lat, 32'd4);
      chk($sformatf("vec%0d_mis", i), {31'b0, mis}, 32'd0);
    end

    // Two-cycle memory latency stretches both accesses
    mem_lat = 2;
    mem[32'h180] = 32'd10;
    do_op(T_ADD, 32'h180, 32'd5, -1, 32'h0, rd, mis, lat);
    chk("slow_lat", lat, 32'd8);
    chk("slow_mem", mem_get(32'h180), 32'd15);
    mem_lat = 0;

    // LR then SC in the same granule succeeds; a second SC fails silently
    mem[32'h200] = 32'hDEAD0200;
    do_op(T_LR, 32'h200, 32'h0, -1, 32'h0, rd, mis, lat);
    chk("lr_rdata", rd, 32'hDEAD0200);
    chk("lr_lat", lat, 32'd2);
    s_wr = n_wr;
    do_op(T_SC, 32'h204, 32'hAB, -1, 32'h0, rd, mis, lat);
    chk("sc1_rdata", rd, 32'd0);
    chk("sc1_mem", mem_get(32'h204), 32'hAB);
    chk("sc1_waddr", last_wr_addr, 32'h204);
    chk("sc1_nwr", n_wr - s_wr, 32'd1);
    s_acc = n_access_cyc;
    do_op(T_SC, 32'h204, 32'hCD, -1, 32'h0, rd, mis, lat);
    chk("sc2_rdata", rd, 32'd1);
    chk("sc2_traffic", n_access_cyc - s_acc, 32'd0);
    chk("sc2_lat", lat, 32'd1);
    chk("sc2_mem", mem_get(32'h204), 32'hAB);

    // Snoop to reserved granule kills SC; snoop elsewhere does not
    do_op(T_LR, 32'h200, 32'h0, -1, 32'h0, rd, mis, lat);
    do_snoop(32'h200);
    s_acc = n_access_cyc;
    do_op(T_SC, 32'h200, 32'h55, -1, 32'h0, rd, mis, lat);
    chk("snoophit_sc", rd, 32'd1);
    chk("snoophit_traffic", n_access_cyc - s_acc, 32'd0);
    do_op(T_LR, 32'h200, 32'h0, -1, 32'h0, rd, mis, lat);
    do_snoop(32'h300);
    do_op(T_SC, 32'h200, 32'h66, -1, 32'h0, rd, mis, lat);
    chk("snoopmiss_sc", rd, 32'd0);
    chk("snoopmiss_mem", mem_get(32'h200), 32'h66);

    // Snoop in the SC accept cycle
    do_op(T_LR, 32'h200, 32'h0, -1, 32'h0, rd, mis, lat);
    do_op(T_SC, 32'h200, 32'h77, 0, 32'h204, rd, mis, lat);
    chk("snoop_at_sc", rd, 32'd1);
    // Snoop in the LR response cycle
    do_op(T_LR, 32'h200, 32'h0, 1, 32'h200, rd, mis, lat);
    do_op(T_SC, 32'h200, 32'h78, -1, 32'h0, rd, mis, lat);
    chk("snoop_at_lr", rd, 32'd1);
    // Own AMO to the reserved granule keeps the reservation
    do_op(T_LR, 32'h200, 32'h0, -1, 32'h0, rd, mis, lat);
    do_op(T_ADD, 32'h204, 32'h1, -1, 32'h0, rd, mis, lat);
    do_op(T_SC, 32'h200, 32'h79, -1, 32'h0, rd, mis, lat);
    chk("own_amo_sc", rd, 32'd0);

    // Misaligned: immediate fault, no memory traffic
    s_acc = n_access_cyc;
    do_op(T_SWAP, 32'h102, 32'h1, -1, 32'h0, rd, mis, lat);
    chk("mis_flag", {31'b0, mis}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_lat", lat, 32'd1);
    chk("mis_traffic", n_access_cyc - s_acc, 32'd0);

    // Reset while the write is outstanding
    do_op(T_LR, 32'h200, 32'h0, -1, 32'h0, rd, mis, lat);
    pre = mem_get(32'h208);
    hold_wr = 1'b1;
    req_valid = 1'b1; req_funct5 = T_SWAP; req_addr = 32'h208; req_operand = 32'h5A5A5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk);
      if (mem_write) saw = 1'b1;
    end
    chk("rstw_reached_write", {31'b0, saw}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstw_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rstw_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rstw_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rstw_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    hold_wr = 1'b0; reset = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid || mem_write || mem_read) bad++;
    end
    chk("rstw_quiet", bad, 32'd0);
    chk("rstw_mem_kept", mem_get(32'h208), pre);
    do_op(T_SC, 32'h200, 32'h1, -1, 32'h0, rd, mis, lat);
    chk("rstw_rsv_cleared", rd, 32'd1);

    // Randomized ops against the behavioural model
    ref_mem = mem;
    m_rsv_v = 1'b0;
    for (int n = 0; n < 200; n++) begin
      logic [4:0] f;
      logic [31:0] a, opd, sa, e_rd;
      logic e_mis;
      int sc, e_nrd, e_nwr, e_lat, k;
      logic [4:0] ops [11];
      ops = '{T_ADD, T_SWAP, T_LR, T_SC, T_XOR, T_OR, T_AND, T_MIN, T_MAX, T_MINU, T_MAXU};
      k = $urandom_range(0, 14);
      if (k < 11) f = ops[k];
      else if (k < 13) f = (k == 11) ? T_LR : T_SC;
      else f = 5'($urandom);
      mem_lat = $urandom_range(0, 2);
      a = 32'h400 + 4 * $urandom_range(0, 5);
      if (f != T_LR && f != T_SC && $urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
      opd = ($urandom_range(0, 3) == 0) ? 32'h80000000 + $urandom_range(0, 3) : $urandom;
      sa = 32'h400 + 4 * $urandom_range(0, 5);
      sc = $urandom_range(0, 5) == 0 ? 0 : -1;
      if (mem_lat == 0 && $urandom_range(0, 5) == 0) sc = 1;
      if ($urandom_range(0, 6) == 0) begin
        do_snoop(sa);
        if (m_rsv_v && (sa >> GRAN) == m_rsv_g) m_rsv_v = 1'b0;
      end
      model_op(f, a, opd, sc, sa, e_rd, e_mis, e_nrd, e_nwr, e_lat);
      s_rd = n_rd; s_wr = n_wr;
      do_op(f, a, opd, sc, sa, rd, mis, lat);
      chk($sformatf("rnd%0d_rdata", n), rd, e_rd);
      chk($sformatf("rnd%0d_mis", n), {31'b0, mis}, {31'b0, e_mis});
      chk($sformatf("rnd%0d_lat", n), lat, e_lat);
      chk($sformatf("rnd%0d_nrd", n), n_rd - s_rd, e_nrd);
      chk($sformatf("rnd%0d_nwr", n), n_wr - s_wr, e_nwr);
      if (!e_mis) chk($sformatf("rnd%0d_mem", n), mem_get(a), ref_get(a));
    end

    chk("rw_overlap", n_rw_overlap, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
